mult_control: RTL and testbench
===============================

# mult_control

Sequencing controller for the 8x8 sequential multiplier. It accepts a start request and captures operands. It then drives the shared 4x4 multiplier's nibble-select mux, the shifter and the accumulator through four partial-product steps, and reports completion or protocol error. It sits between the system-level request logic and the multiplier datapath (operand registers, 4x4 multiplier, shifter, 16-bit accumulator).

## Interface
Parameters:
- none; step count (4) and encodings are fixed constants in the shared package.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- aclr  in  1  asynchronous, active-high reset
- start  in  1  request; sampled every rising edge
- ld_ops  out  1  one-cycle pulse: datapath registers operands a[7:0], b[7:0]
- input_sel  out  2  nibble pair to 4x4 multiplier: 00 a_lo*b_lo, 01 a_lo*b_hi, 10 a_hi*b_lo, 11 a_hi*b_hi
- shift_sel  out  2  partial-product shift: 00 by 0, 01 by 4, 10 by 8, 11 unused
- acc_clr  out  1  accumulator loads shifted product instead of adding
- acc_en  out  1  accumulator updates this edge
- busy  out  1  high in CALC
- done  out  1  one-cycle pulse; accumulator holds valid 16-bit product
- err  out  1  high while in ERR
- state_out  out  2  IDLE 00, CALC 01, DONE 10, ERR 11

## Operation
- States: IDLE, CALC, DONE, ERR. Internal 2-bit step counter, step 0..3, meaningful only in CALC.
- IDLE: start=1 -> CALC. Asserts ld_ops in the same cycle. Clears step to 0.
- CALC, step s: acc_en=1, acc_clr=(s==0). Outputs by step:
  - s0: input_sel 00, shift_sel 00
  - s1: input_sel 01, shift_sel 01
  - s2: input_sel 10, shift_sel 01
  - s3: input_sel 11, shift_sel 10
- Step increments each CALC cycle. At s3 with start=0 -> DONE.
- start=1 on any CALC cycle, including s3 -> ERR. Abort: acc_en=0 that cycle, no done.
- DONE: done=1 for one cycle. start=1 -> CALC with ld_ops=1, giving back-to-back operation. Otherwise -> IDLE.
- ERR: err=1, all datapath controls 0. Stays in ERR while start=1. start=0 -> IDLE.
- Outside CALC: input_sel=00, shift_sel=00, acc_en=0, acc_clr=0.
- All outputs are decoded from registered state/step, except ld_ops. ld_ops = start & (IDLE | DONE).

## Timing
- Reset (aclr=1, any time including mid-CALC): state IDLE, step 0, all outputs 0, state_out 00. Takes effect immediately, without a clock edge.
- Deassertion of aclr: first active edge may accept start.
- Latency: start sampled at edge E0 -> CALC s0..s3 in cycles after E0..E3. Accumulator updates at E1..E4. done high in cycle after E4; product valid then.
- Throughput: one product per 5 cycles. Back-to-back achieved by holding start through the DONE cycle.
- start must be a single-cycle pulse during a multiply. Any high sample while busy is an error.
- Step counter wraps 3 -> 0 only on the CALC exit; it never free-runs.

## Structure
- Package mult_pkg holds:
  - state enum and encodings (IDLE/CALC/DONE/ERR)
  - INPUT_SEL_* and SHIFT_* constants
  - NUM_STEPS = 4
- One sub-module, mult_step_cnt. It is a 2-bit counter with async active-high clear, sync clear and enable, and a terminal-count flag (count==3).
- The FSM, output decode and ld_ops logic live in mult_control.

## Test plan
- Reset mid-CALC: assert aclr during s2, without a clock edge -> all outputs 0, state_out 00 immediately. After release, start -> s0 restarts with acc_clr=1.
- Single multiply: start pulse with a=8'hFF, b=8'hFF and a behavioural datapath model. Required sequence:
  - input_sel 00,01,10,11 and shift_sel 00,01,01,10 on consecutive cycles
  - done exactly 4 cycles after the CALC entry cycle
  - product 16'hFE01
- Back-to-back: a=12, b=13, then start held in DONE with a=200, b=3 -> second CALC follows DONE with no IDLE cycle. Products 156 and 600; two done pulses 5 cycles apart.
- Error: start re-asserted at s1 -> ERR next cycle, err=1, acc_en=0, no done pulse. Hold start 3 cycles -> remain ERR. Drop start -> IDLE.
- Error at s3 boundary: start=1 on s3 -> ERR, not DONE. Subsequent clean start with a=7, b=9 -> product 63.
- Idle stability: start=0 for 20 cycles after reset -> state_out 00, ld_ops/acc_en/done never asserted.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants for the 8x8 sequential multiplier controller: FSM encoding,
// datapath select codes and the per-step select schedule.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

    localparam int unsigned NUM_STEPS = 4;
    localparam logic [1:0]  LAST_STEP = 2'(NUM_STEPS - 1);

    localparam logic [1:0] INPUT_SEL_LL = 2'b00;  // a_lo * b_lo
    localparam logic [1:0] INPUT_SEL_LH = 2'b01;  // a_lo * b_hi
    localparam logic [1:0] INPUT_SEL_HL = 2'b10;  // a_hi * b_lo
    localparam logic [1:0] INPUT_SEL_HH = 2'b11;  // a_hi * b_hi

    localparam logic [1:0] SHIFT_0 = 2'b00;
    localparam logic [1:0] SHIFT_4 = 2'b01;
    localparam logic [1:0] SHIFT_8 = 2'b10;

    function automatic logic [1:0] step_input_sel(input logic [1:0] step);
        case (step)
            2'd0:    return INPUT_SEL_LL;
            2'd1:    return INPUT_SEL_LH;
            2'd2:    return INPUT_SEL_HL;
            default: return INPUT_SEL_HH;
        endcase
    endfunction

    function automatic logic [1:0] step_shift_sel(input logic [1:0] step);
        case (step)
            2'd0:    return SHIFT_0;
            2'd1:    return SHIFT_4;
            2'd2:    return SHIFT_4;
            default: return SHIFT_8;
        endcase
    endfunction

endpackage

// File: rtl/mult_step_cnt.sv
// 2-bit partial-product step counter with async clear, sync clear, enable and
// a terminal-count flag on the last step.
module mult_step_cnt
    import mult_pkg::*;
(
    input  logic       clk,
    input  logic       aclr,
    input  logic       sclr,
    input  logic       en,
    output logic [1:0] count,
    output logic       tc
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr)
            count <= 2'd0;
        else if (sclr)
            count <= 2'd0;
        else if (en)
            count <= count + 2'd1;
    end

    assign tc = (count == LAST_STEP);

endmodule

// File: rtl/mult_control.sv
// Sequencing FSM for the 8x8 multiplier: captures operands, walks the shared
// 4x4 multiplier through four partial products and flags completion or misuse.
module mult_control
    import mult_pkg::*;
(
    input  logic       clk,
    input  logic       aclr,
    input  logic       start,
    output logic       ld_ops,
    output logic [1:0] input_sel,
    output logic [1:0] shift_sel,
    output logic       acc_clr,
    output logic       acc_en,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] state_out
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] step;
    logic       step_tc;
    logic       in_calc;

    assign in_calc = (state == ST_CALC);

    // Counter is held at zero outside CALC, so every CALC entry starts at step 0
    // and the natural 3 -> 0 wrap coincides with the CALC exit.
    mult_step_cnt u_step_cnt (
        .clk   (clk),
        .aclr  (aclr),
        .sclr  (!in_calc),
        .en    (in_calc),
        .count (step),
        .tc    (step_tc)
    );

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_CALC;
            ST_CALC: begin
                if (start)
                    state_nxt = ST_ERR;
                else if (step_tc)
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = start ? ST_CALC : ST_IDLE;
            ST_ERR:  if (!start) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        input_sel = INPUT_SEL_LL;
        shift_sel = SHIFT_0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            ST_CALC: begin
                busy      = 1'b1;
                input_sel = step_input_sel(step);
                shift_sel = step_shift_sel(step);
                // A start seen while busy aborts: the accumulator must not update.
                acc_en    = !start;
                acc_clr   = !start && (step == 2'd0);
            end
            ST_DONE: done = 1'b1;
            ST_ERR:  err  = 1'b1;
            default: ;
        endcase
    end

    // Reset forces every output low, including this combinational pulse.
    assign ld_ops    = !aclr && start && (state == ST_IDLE || state == ST_DONE);
    assign state_out = state;

endmodule

// File: tb/tb_mult_control.sv
// Self-checking bench for mult_control with a behavioural operand/accumulator
// datapath; expected products come from plain a*b arithmetic.
module tb_mult_control;

    logic       clk = 1'b0;
    logic       aclr;
    logic       start;
    logic       ld_ops;
    logic [1:0] input_sel;
    logic [1:0] shift_sel;
    logic       acc_clr;
    logic       acc_en;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] state_out;

    logic [7:0]  op_a, op_b;
    logic [7:0]  reg_a, reg_b;
    logic [15:0] acc_m;
    int          cyc = 0;
    int          done_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic [11:0] obs;
    assign obs = {state_out, ld_ops, busy, acc_en, acc_clr, input_sel, shift_sel, done, err};

    localparam logic [11:0] V_IDLE    = 12'h000;
    localparam logic [11:0] V_IDLE_LD = {2'b00, 1'b1, 9'b0};
    localparam logic [11:0] V_DONE    = {2'b10, 8'b0, 1'b1, 1'b0};
    localparam logic [11:0] V_DONE_LD = {2'b10, 1'b1, 7'b0, 1'b1, 1'b0};
    localparam logic [11:0] V_ERR     = {2'b11, 9'b0, 1'b1};

    mult_control dut (
        .clk       (clk),
        .aclr      (aclr),
        .start     (start),
        .ld_ops    (ld_ops),
        .input_sel (input_sel),
        .shift_sel (shift_sel),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    // Datapath model: operand registers, 4x4 multiplier, shifter, accumulator.
    function automatic logic [15:0] dp_term(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] isel, input logic [1:0] ssel);
        logic [3:0]  na, nb;
        logic [15:0] p;
        na = isel[1] ? a[7:4] : a[3:0];
        nb = isel[0] ? b[7:4] : b[3:0];
        p  = 16'(na) * 16'(nb);
        return p << (4 * int'(ssel));
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ld_ops) begin
            reg_a <= op_a;
            reg_b <= op_b;
        end
        if (acc_en)
            acc_m <= acc_clr ? dp_term(reg_a, reg_b, input_sel, shift_sel)
                             : acc_m + dp_term(reg_a, reg_b, input_sel, shift_sel);
    end

    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    // Expected CALC outputs for step s: nibble pair s, shift of 4 per high nibble used.
    function automatic logic [11:0] calc_exp(input int s, input bit abort);
        logic [1:0] sel;
        sel = 2'(s);
        return {2'b01, 1'b0, 1'b1, !abort, (s == 0) && !abort, sel,
                2'(int'(sel[1]) + int'(sel[0])), 2'b00};
    endfunction

    task automatic run_calc(input logic [15:0] exp_prod, input string tag);
        for (int s = 0; s < 4; s++) begin
            #1;
            n_tests++;
            if (obs !== calc_exp(s, 1'b0)) begin
                n_fail++;
                $display("FAIL %s calc step %0d: got %h expected %h", tag, s, obs, calc_exp(s, 1'b0));
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (obs !== (start ? V_DONE_LD : V_DONE)) begin
            n_fail++;
            $display("FAIL %s done cycle: got %h expected %h", tag, obs, start ? V_DONE_LD : V_DONE);
        end
        n_tests++;
        if (acc_m !== exp_prod) begin
            n_fail++;
            $display("FAIL %s product: got %h expected %h", tag, acc_m, exp_prod);
        end
    endtask

    task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input string tag);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        #1;
        n_tests++;
        if (obs !== V_IDLE_LD) begin
            n_fail++;
            $display("FAIL %s ld_ops: got %h expected %h", tag, obs, V_IDLE_LD);
        end
        @(negedge clk);
        start = 1'b0;
        run_calc(16'(a) * 16'(b), tag);
        @(negedge clk);
        #1;
        n_tests++;
        if (obs !== V_IDLE) begin
            n_fail++;
            $display("FAIL %s return to idle: got %h expected %h", tag, obs, V_IDLE);
        end
    endtask

    task automatic abort_at(input int k, input int hold, input string tag);
        int nd;
        op_a  = 8'($urandom);
        op_b  = 8'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int s = 0; s < k; s++) @(negedge clk);
        start = 1'b1;
        nd = done_cnt;
        #1;
        n_tests++;
        if (obs !== calc_exp(k, 1'b1)) begin
            n_fail++;
            $display("FAIL %s abort cycle s%0d: got %h expected %h", tag, k, obs, calc_exp(k, 1'b1));
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (obs !== V_ERR) begin
                n_fail++;
                $display("FAIL %s err hold %0d: got %h expected %h", tag, h, obs, V_ERR);
            end
        end
        start = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if (obs !== V_IDLE) begin
            n_fail++;
            $display("FAIL %s err release: got %h expected %h", tag, obs, V_IDLE);
        end
        n_tests++;
        if (done_cnt !== nd) begin
            n_fail++;
            $display("FAIL %s spurious done: got %0d expected %0d", tag, done_cnt - nd, 0);
        end
    endtask

    task automatic test_reset();
        aclr  = 1'b1;
        start = 1'b0;
        op_a  = 8'h00;
        op_b  = 8'h00;
        #1;
        n_tests++;
        if (obs !== V_IDLE) begin
            n_fail++;
            $display("FAIL reset state: got %h expected %h", obs, V_IDLE);
        end
        @(negedge clk);
        aclr = 1'b0;
    endtask

    task automatic test_idle();
        int ld0, dn0;
        dn0 = done_cnt;
        ld0 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (obs !== V_IDLE) begin
                n_fail++;
                $display("FAIL idle cycle %0d: got %h expected %h", i, obs, V_IDLE);
            end
        end
        n_tests++;
        if (done_cnt !== dn0) begin
            n_fail++;
            $display("FAIL idle done pulses: got %0d expected %0d", done_cnt - dn0, ld0);
        end
    endtask

    task automatic test_reset_mid_calc();
        op_a  = 8'h5A;
        op_b  = 8'hC3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (obs !== calc_exp(2, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_mid reached s2: got %h expected %h", obs, calc_exp(2, 1'b0));
        end
        #1 aclr = 1'b1;
        #1;
        n_tests++;
        if (obs !== V_IDLE) begin
            n_fail++;
            $display("FAIL reset_mid async: got %h expected %h", obs, V_IDLE);
        end
        @(negedge clk);
        aclr = 1'b0;
        run_mult(8'($urandom), 8'($urandom), "reset_restart");
    endtask

    task automatic test_single();
        @(negedge clk);
        run_mult(8'hFF, 8'hFF, "single_ff");
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        @(negedge clk);
        op_a  = 8'd12;
        op_b  = 8'd13;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_calc(16'd156, "b2b_first");
        t1    = cyc;
        op_a  = 8'd200;
        op_b  = 8'd3;
        start = 1'b1;
        #1;
        n_tests++;
        if (obs !== V_DONE_LD) begin
            n_fail++;
            $display("FAIL b2b restart in done: got %h expected %h", obs, V_DONE_LD);
        end
        @(negedge clk);
        start = 1'b0;
        run_calc(16'd600, "b2b_second");
        t2 = cyc;
        n_tests++;
        if (t2 - t1 !== 5) begin
            n_fail++;
            $display("FAIL b2b done spacing: got %0d expected %0d", t2 - t1, 5);
        end
        @(negedge clk);
    endtask

    task automatic test_error();
        abort_at(1, 3, "err_s1");
    endtask

    task automatic test_error_s3();
        abort_at(3, 1, "err_s3");
        run_mult(8'd7, 8'd9, "after_err_s3");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0)
                abort_at(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), "rand_abort");
            else
                run_mult(8'($urandom), 8'($urandom), "rand_mult");
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_reset_mid_calc();
        test_back_to_back();
        test_error();
        test_error_s3();
        test_random();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
